// File: rtl/lsb_queue_pkg.sv
// lsb_queue_pkg: shared encodings for the load/store queue.
//   - NULL_TAG      : ROB tag value meaning "operand already valid"
//   - SZ_*          : memory access size encodings driven on mem_size
//   - lsb_state_e   : issue FSM state encoding
//   - f3_size / f3_unsigned : decode of RV load/store funct3
package lsb_queue_pkg;

    localparam int NULL_TAG = 0;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DRAIN = 2'd3
    } lsb_state_e;

    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/lsb_queue_cdb_match.sv
// lsb_cdb_match: operand snoop for one (q, v) pair.
//   q_in/v_in   : current producer tag and value
//   port_valid  : per-port broadcast strobe
//   port_tag    : packed tags, port p at [p*TAG_W +: TAG_W]
//   port_data   : packed data, port p at [p*XLEN +: XLEN]
//   q_out/v_out : tag cleared and value captured on a match; the
//                 lowest-numbered matching port wins.
module lsb_cdb_match
    import lsb_queue_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32,
    parameter int N_PORTS = 2
) (
    input  logic [TAG_W-1:0]         q_in,
    input  logic [XLEN-1:0]          v_in,
    input  logic [N_PORTS-1:0]       port_valid,
    input  logic [N_PORTS*TAG_W-1:0] port_tag,
    input  logic [N_PORTS*XLEN-1:0]  port_data,
    output logic [TAG_W-1:0]         q_out,
    output logic [XLEN-1:0]          v_out
);

    logic hit;

    always_comb begin
        q_out = q_in;
        v_out = v_in;
        hit   = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!hit && q_in != TAG_W'(NULL_TAG) && port_valid[p] &&
                port_tag[p*TAG_W +: TAG_W] == q_in) begin
                q_out = TAG_W'(NULL_TAG);
                v_out = port_data[p*XLEN +: XLEN];
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue.
//   Dispatcher side : alloc_* enqueue, full/count back-pressure.
//   Operand snoop   : N_CDB common data buses (cdb_valid/tag/data).
//   ROB side        : rob_head_tag (IO load gating), commit_* (store
//                     commit), rollback (flush), commit_err (sticky).
//   Memory side     : mem_req/we/addr/size/wdata request pulse,
//                     mem_ready/mem_rdata completion pulse.
//   Load result     : ld_valid/ld_tag/ld_data, one cycle after mem_ready.
module lsb_queue
    import lsb_queue_pkg::*;
#(
    parameter int              DEPTH   = 16,
    parameter int              TAG_W   = 4,
    parameter int              XLEN    = 32,
    parameter int              N_CDB   = 2,
    parameter logic [XLEN-1:0] IO_BASE = 32'h0003_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     alloc_valid,
    input  logic                     alloc_is_store,
    input  logic [2:0]               alloc_funct3,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic [XLEN-1:0]          alloc_vj,
    input  logic [XLEN-1:0]          alloc_vk,
    input  logic [TAG_W-1:0]         alloc_qj,
    input  logic [TAG_W-1:0]         alloc_qk,
    input  logic [XLEN-1:0]          alloc_imm,
    input  logic [N_CDB-1:0]         cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [N_CDB*XLEN-1:0]    cdb_data,
    input  logic [TAG_W-1:0]         rob_head_tag,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     rollback,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [1:0]               mem_size,
    output logic [XLEN-1:0]          mem_wdata,
    input  logic                     mem_ready,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     ld_valid,
    output logic [TAG_W-1:0]         ld_tag,
    output logic [XLEN-1:0]          ld_data,
    output logic                     commit_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NP    = N_CDB + 1;

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] res;
        logic            fill;
        fill = 1'b0;
        res  = raw;
        case (f3_size(f3))
            SZ_BYTE: begin
                fill = ~f3_unsigned(f3) & raw[7];
                res  = {{(XLEN-8){fill}}, raw[7:0]};
            end
            SZ_HALF: begin
                fill = ~f3_unsigned(f3) & raw[15];
                res  = {{(XLEN-16){fill}}, raw[15:0]};
            end
            SZ_WORD: res = raw;
            default: res = raw;
        endcase
        return res;
    endfunction

    logic              slot_is_store  [DEPTH];
    logic [2:0]        slot_f3        [DEPTH];
    logic [TAG_W-1:0]  slot_tag       [DEPTH];
    logic [XLEN-1:0]   slot_vj        [DEPTH];
    logic [TAG_W-1:0]  slot_qj        [DEPTH];
    logic [XLEN-1:0]   slot_vk        [DEPTH];
    logic [TAG_W-1:0]  slot_qk        [DEPTH];
    logic [XLEN-1:0]   slot_imm       [DEPTH];
    logic              slot_committed [DEPTH];

    logic [TAG_W-1:0]  upd_qj [DEPTH];
    logic [TAG_W-1:0]  upd_qk [DEPTH];
    logic [XLEN-1:0]   upd_vj [DEPTH];
    logic [XLEN-1:0]   upd_vk [DEPTH];

    logic [PTR_W-1:0]  head, tail, cidx;
    logic [CNT_W-1:0]  ccnt, next_count;
    lsb_state_e        state;

    logic [TAG_W-1:0]  inflight_tag_p0;
    logic [2:0]        inflight_f3_p0;

    // The completing load acts as an extra, lowest-priority snoop port
    // so queued consumers pick up its result on the mem_ready edge.
    logic              fwd_valid;
    logic [XLEN-1:0]   ld_result;
    logic [NP-1:0]       snp_valid;
    logic [NP*TAG_W-1:0] snp_tag;
    logic [NP*XLEN-1:0]  snp_data;

    assign ld_result = load_extend(inflight_f3_p0, mem_rdata);
    assign fwd_valid = (state == ST_LOAD) && mem_ready && !rollback;
    assign snp_valid = {fwd_valid, cdb_valid};
    assign snp_tag   = {inflight_tag_p0, cdb_tag};
    assign snp_data  = {ld_result, cdb_data};

    logic [TAG_W-1:0]  a_qj, a_qk;
    logic [XLEN-1:0]   a_vj, a_vk;

    lsb_cdb_match #(.TAG_W(TAG_W), .XLEN(XLEN), .N_PORTS(NP)) u_alloc_j (
        .q_in(alloc_qj), .v_in(alloc_vj), .port_valid(snp_valid),
        .port_tag(snp_tag), .port_data(snp_data), .q_out(a_qj), .v_out(a_vj));

    lsb_cdb_match #(.TAG_W(TAG_W), .XLEN(XLEN), .N_PORTS(NP)) u_alloc_k (
        .q_in(alloc_qk), .v_in(alloc_vk), .port_valid(snp_valid),
        .port_tag(snp_tag), .port_data(snp_data), .q_out(a_qk), .v_out(a_vk));

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        lsb_cdb_match #(.TAG_W(TAG_W), .XLEN(XLEN), .N_PORTS(NP)) u_j (
            .q_in(slot_qj[i]), .v_in(slot_vj[i]), .port_valid(snp_valid),
            .port_tag(snp_tag), .port_data(snp_data),
            .q_out(upd_qj[i]), .v_out(upd_vj[i]));
        lsb_cdb_match #(.TAG_W(TAG_W), .XLEN(XLEN), .N_PORTS(NP)) u_k (
            .q_in(slot_qk[i]), .v_in(slot_vk[i]), .port_valid(snp_valid),
            .port_tag(snp_tag), .port_data(snp_data),
            .q_out(upd_qk[i]), .v_out(upd_vk[i]));
    end

    logic [XLEN-1:0] head_addr;
    logic            head_store, head_ready, issue, store_issue;
    logic            alloc_accept, commit_do;

    assign head_addr  = slot_vj[head] + slot_imm[head];
    assign head_store = slot_is_store[head];

    // IO loads must not issue speculatively: they wait for the ROB head.
    always_comb begin
        head_ready = 1'b0;
        if (count != '0) begin
            if (head_store)
                head_ready = slot_qj[head] == TAG_W'(NULL_TAG) &&
                             slot_qk[head] == TAG_W'(NULL_TAG) &&
                             slot_committed[head];
            else
                head_ready = slot_qj[head] == TAG_W'(NULL_TAG) &&
                             (head_addr < IO_BASE || slot_tag[head] == rob_head_tag);
        end
    end

    assign issue        = (state == ST_IDLE) && head_ready && !rollback;
    assign store_issue  = issue && head_store;
    assign alloc_accept = alloc_valid && !full && !rollback;
    assign commit_do    = commit_valid && !rollback;
    // Committed-unissued stores occupy head..head+ccnt-1, so the next
    // commit always lands just past them.
    assign cidx         = head + ccnt[PTR_W-1:0];
    assign next_count   = count + CNT_W'(alloc_accept) - CNT_W'(issue);

    // Slot storage: operand snooping every cycle, tail write on alloc.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_qj[i] <= upd_qj[i];
            slot_vj[i] <= upd_vj[i];
            slot_qk[i] <= upd_qk[i];
            slot_vk[i] <= upd_vk[i];
        end
        if (alloc_accept) begin
            slot_is_store[tail]  <= alloc_is_store;
            slot_f3[tail]        <= alloc_funct3;
            slot_tag[tail]       <= alloc_tag;
            slot_imm[tail]       <= alloc_imm;
            slot_qj[tail]        <= a_qj;
            slot_vj[tail]        <= a_vj;
            slot_qk[tail]        <= a_qk;
            slot_vk[tail]        <= a_vk;
            slot_committed[tail] <= 1'b0;
        end
        if (commit_do)
            slot_committed[cidx] <= 1'b1;
        if (issue) begin
            inflight_tag_p0 <= slot_tag[head];
            inflight_f3_p0  <= slot_f3[head];
        end
    end

    // Control: pointers, counters, issue FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            full       <= 1'b0;
            ccnt       <= '0;
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_size   <= '0;
            mem_wdata  <= '0;
            ld_valid   <= 1'b0;
            ld_tag     <= '0;
            ld_data    <= '0;
            commit_err <= 1'b0;
        end else begin
            mem_req  <= 1'b0;
            ld_valid <= 1'b0;

            if (commit_do && (!slot_is_store[cidx] || slot_tag[cidx] != commit_tag))
                commit_err <= 1'b1;

            if (rollback) begin
                // Keep only committed-unissued stores, which sit at the head.
                tail  <= head + ccnt[PTR_W-1:0];
                count <= ccnt;
                full  <= (ccnt == CNT_W'(DEPTH));
            end else begin
                tail  <= tail + PTR_W'(alloc_accept);
                count <= next_count;
                full  <= (next_count == CNT_W'(DEPTH));
            end
            head <= head + PTR_W'(issue);
            ccnt <= ccnt + CNT_W'(commit_do) - CNT_W'(store_issue);

            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        mem_req   <= 1'b1;
                        mem_we    <= head_store;
                        mem_addr  <= head_addr;
                        mem_size  <= f3_size(slot_f3[head]);
                        mem_wdata <= slot_vk[head];
                        state     <= head_store ? ST_STORE : ST_LOAD;
                    end
                end
                ST_STORE: begin
                    if (mem_ready) state <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (mem_ready) begin
                        state <= ST_IDLE;
                        if (!rollback) begin
                            ld_valid <= 1'b1;
                            ld_tag   <= inflight_tag_p0;
                            ld_data  <= ld_result;
                        end
                    end else if (rollback) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
module tb_lsb_queue;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;
    localparam int N_CDB = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   full;
    logic [4:0]             count;
    logic                   alloc_valid, alloc_is_store;
    logic [2:0]             alloc_funct3;
    logic [TAG_W-1:0]       alloc_tag, alloc_qj, alloc_qk;
    logic [XLEN-1:0]        alloc_vj, alloc_vk, alloc_imm;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB*XLEN-1:0]  cdb_data;
    logic [TAG_W-1:0]       rob_head_tag;
    logic                   commit_valid;
    logic [TAG_W-1:0]       commit_tag;
    logic                   rollback;
    logic                   mem_req, mem_we;
    logic [XLEN-1:0]        mem_addr, mem_wdata;
    logic [1:0]             mem_size;
    logic                   mem_ready;
    logic [XLEN-1:0]        mem_rdata;
    logic                   ld_valid;
    logic [TAG_W-1:0]       ld_tag;
    logic [XLEN-1:0]        ld_data;
    logic                   commit_err;

    lsb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .N_CDB(N_CDB),
                .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst(rst), .full(full), .count(count),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_funct3(alloc_funct3), .alloc_tag(alloc_tag),
        .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
        .alloc_qj(alloc_qj), .alloc_qk(alloc_qk), .alloc_imm(alloc_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_head_tag(rob_head_tag), .commit_valid(commit_valid),
        .commit_tag(commit_tag), .rollback(rollback),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
        .commit_err(commit_err));

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } lres_t;

    mreq_t exp_mem[$];
    lres_t exp_ld[$];
    mreq_t mon_m;
    lres_t mon_l;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_m(input logic we, input logic [31:0] a, input logic [1:0] s,
                         input logic [31:0] w);
        exp_mem.push_back('{we: we, addr: a, size: s, wdata: w});
    endtask

    task automatic exp_l(input logic [3:0] t, input logic [31:0] d);
        exp_ld.push_back('{tag: t, data: d});
    endtask

    // Monitor: every presented request/result is checked against the
    // oldest expectation; anything presented with nothing expected fails.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                if (exp_mem.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_mem_req: got addr 0x%0h we %0b, want no request",
                             mem_addr, mem_we);
                end else begin
                    mon_m = exp_mem.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(mon_m.we));
                    chk("mem_addr", 64'(mem_addr), 64'(mon_m.addr));
                    chk("mem_size", 64'(mem_size), 64'(mon_m.size));
                    if (mon_m.we) chk("mem_wdata", 64'(mem_wdata), 64'(mon_m.wdata));
                end
            end
            if (ld_valid) begin
                if (exp_ld.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ld_valid: got tag %0d data 0x%0h, want none",
                             ld_tag, ld_data);
                end else begin
                    mon_l = exp_ld.pop_front();
                    chk("ld_tag", 64'(ld_tag), 64'(mon_l.tag));
                    chk("ld_data", 64'(ld_data), 64'(mon_l.data));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic alloc(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                         input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk,
                         input logic [31:0] imm);
        alloc_valid = 1'b1; alloc_is_store = st; alloc_funct3 = f3; alloc_tag = tag;
        alloc_vj = vj; alloc_qj = qj; alloc_vk = vk; alloc_qk = qk; alloc_imm = imm;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] t);
        commit_valid = 1'b1; commit_tag = t;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_ready = 1'b1; mem_rdata = d;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k;
        for (k = 0; k < 40; k++) begin
            if (mem_req) break;
            tick();
        end
        if (k == 40) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no mem_req within 40 cycles, want a request", name);
        end
    endtask

    function automatic logic [3:0] tag_of(input int s);
        return 4'((s % 15) + 1);
    endfunction

    int exp_seq[$];
    int seq;

    initial begin
        rst = 1'b1; alloc_valid = 0; alloc_is_store = 0; alloc_funct3 = 0;
        alloc_tag = 0; alloc_vj = 0; alloc_vk = 0; alloc_qj = 0; alloc_qk = 0;
        alloc_imm = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        rob_head_tag = 0; commit_valid = 0; commit_tag = 0; rollback = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_size", 64'(mem_size), 0);
        chk("rst_mem_wdata", 64'(mem_wdata), 0);
        chk("rst_ld_valid", 64'(ld_valid), 0);
        chk("rst_ld_tag", 64'(ld_tag), 0);
        chk("rst_ld_data", 64'(ld_data), 0);
        chk("rst_commit_err", 64'(commit_err), 0);

        // LB sign-extend, with exact alloc-to-request latency
        exp_m(0, 32'h104, 2'd0, 0);
        exp_l(4'd1, 32'hFFFF_FF80);
        alloc(0, 3'b000, 4'd1, 32'h100, 0, 0, 0, 32'd4);
        chk("lat_alloc_edge", 64'(mem_req), 0);
        chk("lat_count", 64'(count), 1);
        tick();
        chk("lat_next_cycle", 64'(mem_req), 1);
        respond(32'h0000_0080);

        // LBU zero-extend
        exp_m(0, 32'h104, 2'd0, 0);
        exp_l(4'd2, 32'h0000_0080);
        alloc(0, 3'b100, 4'd2, 32'h100, 0, 0, 0, 32'd4);
        wait_req("lbu_req");
        respond(32'h0000_0080);

        // LH with negative offset
        exp_m(0, 32'h1FE, 2'd1, 0);
        exp_l(4'd3, 32'hFFFF_9234);
        alloc(0, 3'b001, 4'd3, 32'h200, 0, 0, 0, 32'hFFFF_FFFE);
        wait_req("lh_req");
        respond(32'h0000_9234);

        // SW: data arrives on CDB port 1; no issue before commit
        alloc(1, 3'b010, 4'd5, 32'h300, 0, 0, 4'd3, 32'd8);
        cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd7}; cdb_data = {32'hDEAD_BEEF, 32'h1111_1111};
        tick();
        cdb_valid = 2'b00;
        repeat (4) tick();
        chk("st_hold_precommit", 64'(mem_req), 0);
        exp_m(1, 32'h308, 2'd2, 32'hDEAD_BEEF);
        do_commit(4'd5);
        wait_req("sw_req");
        respond(0);

        // SB: duplicate tag on both ports, port 0 wins
        alloc(1, 3'b000, 4'd6, 32'h400, 0, 0, 4'd4, 32'd1);
        cdb_valid = 2'b11; cdb_tag = {4'd4, 4'd4}; cdb_data = {32'hBBBB_BB6B, 32'hAAAA_AA5A};
        tick();
        cdb_valid = 2'b00;
        exp_m(1, 32'h401, 2'd0, 32'hAAAA_AA5A);
        do_commit(4'd6);
        wait_req("sb_req");
        respond(0);

        // base captured from CDB in the alloc cycle
        exp_m(0, 32'h50C, 2'd2, 0);
        exp_l(4'd7, 32'h0000_0077);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h0000_0500};
        alloc(0, 3'b010, 4'd7, 32'h0, 4'd9, 0, 0, 32'hC);
        cdb_valid = 2'b00;
        wait_req("alloc_capture_req");
        respond(32'h0000_0077);

        // load result forwarded into a queued consumer (LHU)
        exp_m(0, 32'h900, 2'd2, 0);
        exp_l(4'd2, 32'h0000_2000);
        alloc(0, 3'b010, 4'd2, 32'h900, 0, 0, 0, 0);
        wait_req("fwd_producer_req");
        exp_m(0, 32'h2010, 2'd1, 0);
        exp_l(4'd3, 32'h0000_8001);
        alloc(0, 3'b101, 4'd3, 32'h0, 4'd2, 0, 0, 32'h10);
        respond(32'h0000_2000);
        wait_req("fwd_consumer_req");
        respond(32'h1234_8001);

        // IO load waits for ROB head
        rob_head_tag = 4'd1;
        alloc(0, 3'b010, 4'd8, 32'h0003_0000, 0, 0, 0, 32'd4);
        repeat (4) tick();
        chk("io_hold", 64'(mem_req), 0);
        exp_m(0, 32'h0003_0004, 2'd2, 0);
        exp_l(4'd8, 32'hCAFE_0001);
        rob_head_tag = 4'd8;
        tick();
        chk("io_issue_next", 64'(mem_req), 1);
        respond(32'hCAFE_0001);
        rob_head_tag = 4'd0;
        repeat (2) tick();

        // rollback with a load in flight and two committed stores
        exp_m(0, 32'h700, 2'd2, 0);
        alloc(0, 3'b010, 4'd12, 32'h700, 0, 0, 0, 0);
        wait_req("rb_load_req");
        alloc(1, 3'b010, 4'd10, 32'h600, 0, 32'h11, 0, 0);
        alloc(1, 3'b010, 4'd11, 32'h604, 0, 32'h22, 0, 0);
        alloc(0, 3'b010, 4'd13, 32'h40, 0, 0, 0, 0);
        alloc(0, 3'b010, 4'd14, 32'h44, 0, 0, 0, 0);
        alloc(0, 3'b010, 4'd15, 32'h48, 0, 0, 0, 0);
        exp_m(1, 32'h600, 2'd2, 32'h11);
        exp_m(1, 32'h604, 2'd2, 32'h22);
        do_commit(4'd10);
        do_commit(4'd11);
        chk("rb_count_before", 64'(count), 5);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rb_count_after", 64'(count), 2);
        respond(32'h0000_0055);
        chk("rb_ld_dropped", 64'(ld_valid), 0);
        wait_req("rb_store0_req");
        respond(0);
        wait_req("rb_store1_req");
        respond(0);
        repeat (3) tick();
        chk("rb_count_drained", 64'(count), 0);
        chk("rb_commit_err", 64'(commit_err), 0);

        // fill to full, then steady pop/push across pointer wrap
        seq = 0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc(1, 3'b010, tag_of(seq), 32'h1000 + 32'(seq) * 4, 0, 32'(seq), 0, 0);
            exp_seq.push_back(seq);
            seq++;
        end
        chk("fill_full", 64'(full), 1);
        chk("fill_count", 64'(count), 16);
        alloc(1, 3'b010, 4'd1, 32'hDEAD_0000, 0, 0, 0, 0);
        chk("alloc_while_full_ignored", 64'(count), 16);
        for (int it = 0; it < 20; it++) begin
            int s;
            s = exp_seq.pop_front();
            exp_m(1, 32'h1000 + 32'(s) * 4, 2'd2, 32'(s));
            do_commit(tag_of(s));
            wait_req("wrap_store_req");
            respond(0);
            alloc(1, 3'b010, tag_of(seq), 32'h1000 + 32'(seq) * 4, 0, 32'(seq), 0, 0);
            exp_seq.push_back(seq);
            seq++;
        end
        chk("wrap_full", 64'(full), 1);
        chk("wrap_commit_err", 64'(commit_err), 0);

        // commit of the wrong tag is flagged; reset clears it
        do_commit(tag_of(exp_seq[0] + 1));
        chk("commit_err_set", 64'(commit_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_seq.delete();
        chk("commit_err_cleared", 64'(commit_err), 0);
        chk("reset_count", 64'(count), 0);
        chk("reset_full", 64'(full), 0);
        repeat (3) tick();

        chk("mem_expect_drained", 64'(exp_mem.size()), 0);
        chk("ld_expect_drained", 64'(exp_ld.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
